// File: rtl/result_streamer_pkg.sv
// Shared definitions for the result streamer: command-word field layout, opcode and FSM states.
package result_streamer_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int MODE_W     = 32;

   localparam int OP_LSB     = 0;
   localparam int OP_MSB     = 3;
   localparam int BITSER_POS = 4;
   localparam int CNT_LSB    = 8;
   localparam int CNT_MSB    = 15;

   localparam logic [3:0] OP_STREAM = 4'h3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_DONE
   } state_e;
endpackage

// File: rtl/result_streamer_if.sv
// Bus bundle between a controller/sink (master) and the result streamer (slave).
interface result_streamer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6
);
   logic                     enable;
   logic [31:0]              mode;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic signed [DATA_W-1:0] wr_data;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic                     busy;
   logic                     done;

   modport master (
      output enable, mode, wr_en, wr_addr, wr_data, out_ready,
      input  out_data, out_valid, busy, done
   );

   modport slave (
      input  enable, mode, wr_en, wr_addr, wr_data, out_ready,
      output out_data, out_valid, busy, done
   );
endinterface

// File: rtl/result_streamer_ram.sv
// Result buffer: one write port, one registered read port (1-cycle latency, old word on collision).
// Read register only updates when i_rd_en is high, so a fetched word stays put while it is being sent.
module result_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     i_clk,
   input  logic                     i_wr_en,
   input  logic [ADDR_W-1:0]        i_wr_addr,
   input  logic signed [DATA_W-1:0] i_wr_data,
   input  logic                     i_rd_en,
   input  logic [ADDR_W-1:0]        i_rd_addr,
   output logic signed [DATA_W-1:0] o_rd_data
);
   logic signed [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) o_rd_data        <= r_mem[i_rd_addr];
   end
endmodule

// File: rtl/result_streamer.sv
// Streams buffered result words (or their bits LSB-first) over a valid/ready port; one bubble between words.
// Beats hold while out_ready is low; enable low freezes everything, buffer writes are always accepted.
module result_streamer
   import result_streamer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   result_streamer_if.slave  io_bus
);
   localparam int CNT_W = ADDR_W + 1;
   localparam int BIT_W = $clog2(DATA_W);

   state_e             r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
   logic [CNT_W-1:0]   r_left, w_left_nxt;
   logic [BIT_W-1:0]   r_bit, w_bit_nxt;
   logic               r_bitser, w_bitser_nxt;
   logic               r_out_valid, w_valid_nxt;
   logic               w_rd_en;
   logic               w_accept;
   logic [3:0]         w_op;
   logic [7:0]         w_cnt;
   logic [CNT_W-1:0]   w_cnt_clamp;
   logic               w_mode_unused;
   logic signed [DATA_W-1:0] w_ram_q;

   result_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .i_clk     (i_clk),
      .i_wr_en   (io_bus.wr_en),
      .i_wr_addr (io_bus.wr_addr),
      .i_wr_data (io_bus.wr_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_addr),
      .o_rd_data (w_ram_q)
   );

   assign w_op          = io_bus.mode[OP_MSB:OP_LSB];
   assign w_cnt         = io_bus.mode[CNT_MSB:CNT_LSB];
   assign w_mode_unused = ^{io_bus.mode[MODE_W-1:CNT_MSB+1], io_bus.mode[CNT_LSB-1:BITSER_POS+1]};
   assign w_cnt_clamp   = (int'(w_cnt) > DEPTH) ? CNT_W'(DEPTH) : CNT_W'(w_cnt);
   assign w_accept      = r_out_valid && io_bus.out_ready;

   always_comb begin
      w_state_nxt  = r_state;
      w_addr_nxt   = r_addr;
      w_left_nxt   = r_left;
      w_bit_nxt    = r_bit;
      w_bitser_nxt = r_bitser;
      w_valid_nxt  = r_out_valid;
      w_rd_en      = 1'b0;
      if (io_bus.enable) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_op == OP_STREAM) begin
                  if (w_cnt == '0) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_state_nxt  = S_LOAD;
                     w_left_nxt   = w_cnt_clamp;
                     w_bitser_nxt = io_bus.mode[BITSER_POS];
                     w_addr_nxt   = '0;
                     w_bit_nxt    = '0;
                  end
               end
            end
            S_LOAD: begin
               w_rd_en     = 1'b1;
               w_state_nxt = S_SEND;
               w_valid_nxt = 1'b1;
            end
            S_SEND: begin
               if (w_accept) begin
                  // Bits of one word go back-to-back; only a word boundary revisits LOAD.
                  if (r_bitser && (r_bit != BIT_W'(DATA_W - 1))) begin
                     w_bit_nxt = r_bit + BIT_W'(1);
                  end else begin
                     w_bit_nxt   = '0;
                     w_valid_nxt = 1'b0;
                     if (r_left == CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                     end else begin
                        w_state_nxt = S_LOAD;
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_left_nxt  = r_left - CNT_W'(1);
                     end
                  end
               end
            end
            S_DONE: begin
               if (w_op != OP_STREAM) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_left      <= '0;
         r_bit       <= '0;
         r_bitser    <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_left      <= w_left_nxt;
         r_bit       <= w_bit_nxt;
         r_bitser    <= w_bitser_nxt;
         r_out_valid <= w_valid_nxt;
      end
   end

   // Gating on r_out_valid makes out_data drop to zero with the asynchronous reset.
   assign io_bus.out_data  = !r_out_valid ? '0 :
                             r_bitser ? {{(DATA_W-1){1'b0}}, w_ram_q[r_bit]} : w_ram_q;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.busy      = (r_state == S_LOAD) || (r_state == S_SEND);
   assign io_bus.done      = (r_state == S_DONE);
endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: word, bit-serial, backpressure, clamp, re-arm, reset and enable cases.
module tb_result_streamer;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   logic [31:0] beats[$];
   int          bcyc[$];
   bit          timed_out;
   bit          hold_ok;

   result_streamer_if #(.DATA_W(32), .ADDR_W(6)) bus ();

   result_streamer #(.DATA_W(32), .DEPTH(64), .ADDR_W(6)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic rearm();
      bus.mode = 32'h0;
      tick();
      tick();
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!bus.out_valid && n < 10) begin
         tick();
         n++;
      end
      chk_eq(tag, {31'b0, bus.out_valid}, 32'd1);
   endtask

   // Records every accepted beat until done; pause_at >= 0 drops enable for 3 cycles on that beat.
   task automatic collect(input int max_cyc, input int pause_at);
      int c;
      bit paused;
      logic [31:0] held;
      beats.delete();
      bcyc.delete();
      timed_out = 1'b0;
      hold_ok   = 1'b1;
      paused    = 1'b0;
      c = 0;
      while (!bus.done) begin
         if (c >= max_cyc) begin
            timed_out = 1'b1;
            break;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (!paused && beats.size() == pause_at) begin
               paused     = 1'b1;
               held       = bus.out_data;
               bus.enable = 1'b0;
               repeat (3) begin
                  tick();
                  hold_ok &= bus.out_valid && (bus.out_data == held);
               end
               bus.enable = 1'b1;
            end
            beats.push_back(bus.out_data);
            bcyc.push_back(c);
         end
         tick();
         c++;
      end
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] upper;
      int bad;
      bit quiet;

      n_checks = 0;
      n_errors = 0;
      rst_n         = 1'b0;
      bus.enable    = 1'b1;
      bus.mode      = 32'h0;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.out_ready = 1'b1;
      #3;
      chk_eq("rst_valid", {31'b0, bus.out_valid}, 32'd0);
      chk_eq("rst_data", bus.out_data, 32'd0);
      chk_eq("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk_eq("rst_done", {31'b0, bus.done}, 32'd0);

      tick();
      wr(6'd0, 32'd10);
      wr(6'd1, -32'sd3);
      wr(6'd2, 32'd7);
      rst_n = 1'b1;
      tick();

      // Word mode, three beats with a bubble after each.
      bus.mode = 32'h0303;
      collect(50, -1);
      chk_eq("word_timeout", {31'b0, timed_out}, 32'd0);
      chk_eq("word_nbeats", beats.size(), 32'd3);
      if (beats.size() == 3) begin
         chk_eq("word_b0", beats[0], 32'd10);
         chk_eq("word_b1", beats[1], 32'hFFFF_FFFD);
         chk_eq("word_b2", beats[2], 32'd7);
         chk_eq("word_gap01", bcyc[1] - bcyc[0], 32'd2);
         chk_eq("word_gap12", bcyc[2] - bcyc[1], 32'd2);
      end
      chk_eq("word_done", {31'b0, bus.done}, 32'd1);

      // Mode held at OP_STREAM after DONE: no restart.
      quiet = 1'b1;
      repeat (5) begin
         tick();
         quiet &= bus.done && !bus.out_valid && !bus.busy;
      end
      chk_eq("hold_no_restart", {31'b0, quiet}, 32'd1);
      bus.mode = 32'h0;
      tick();
      chk_eq("rearm_idle", {31'b0, bus.done}, 32'd0);
      tick();

      // Backpressure on the first beat of a two-word stream.
      bus.out_ready = 1'b0;
      bus.mode = 32'h0203;
      wait_valid("bp_wait");
      hold_ok = 1'b1;
      repeat (5) begin
         tick();
         hold_ok &= bus.out_valid && (bus.out_data == 32'd10);
      end
      chk_eq("bp_held", {31'b0, hold_ok}, 32'd1);
      bus.out_ready = 1'b1;
      collect(50, -1);
      chk_eq("bp_nbeats", beats.size(), 32'd2);
      if (beats.size() == 2) begin
         chk_eq("bp_b0", beats[0], 32'd10);
         chk_eq("bp_b1", beats[1], 32'hFFFF_FFFD);
      end
      rearm();

      // count == 0 goes straight to DONE.
      bus.mode = 32'h0003;
      tick();
      chk_eq("c0_done", {31'b0, bus.done}, 32'd1);
      chk_eq("c0_valid", {31'b0, bus.out_valid}, 32'd0);
      chk_eq("c0_busy", {31'b0, bus.busy}, 32'd0);
      rearm();

      // Bit-serial with a 3-cycle enable drop on bit 5; word written while enable is low.
      bus.enable = 1'b0;
      wr(6'd0, 32'h0000_00A5);
      bus.enable = 1'b1;
      bus.mode = 32'h0113;
      collect(200, 5);
      chk_eq("bs_timeout", {31'b0, timed_out}, 32'd0);
      chk_eq("bs_nbeats", beats.size(), 32'd32);
      chk_eq("bs_pause_hold", {31'b0, hold_ok}, 32'd1);
      if (beats.size() == 32) begin
         w = '0;
         upper = '0;
         for (int i = 0; i < 32; i++) begin
            w[i] = beats[i][0];
            upper |= {1'b0, beats[i][31:1]};
         end
         chk_eq("bs_word", w, 32'h0000_00A5);
         chk_eq("bs_upper_zero", upper, 32'd0);
         chk_eq("bs_contiguous", bcyc[31] - bcyc[0], 32'd31);
      end
      chk_eq("bs_done", {31'b0, bus.done}, 32'd1);
      rearm();

      // count = 200 clamps to 64 words.
      for (int i = 0; i < 64; i++) wr(6'(i), 32'(i * 7 - 20));
      bus.mode = 32'hC803;
      collect(400, -1);
      chk_eq("c200_timeout", {31'b0, timed_out}, 32'd0);
      chk_eq("c200_nbeats", beats.size(), 32'd64);
      if (beats.size() == 64) begin
         bad = 0;
         for (int i = 0; i < 64; i++) if (beats[i] != 32'(i * 7 - 20)) bad++;
         chk_eq("c200_order", bad, 32'd0);
         chk_eq("c200_last", beats[63], 32'd421);
      end
      rearm();

      // Reset during the second beat of three.
      wr(6'd0, 32'd10);
      wr(6'd1, -32'sd3);
      wr(6'd2, 32'd7);
      bus.mode = 32'h0303;
      wait_valid("rst_ms_wait1");
      tick();
      wait_valid("rst_ms_wait2");
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("rst_ms_valid", {31'b0, bus.out_valid}, 32'd0);
      chk_eq("rst_ms_data", bus.out_data, 32'd0);
      chk_eq("rst_ms_busy", {31'b0, bus.busy}, 32'd0);
      chk_eq("rst_ms_done", {31'b0, bus.done}, 32'd0);
      bus.mode = 32'h0;
      tick();
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (3) begin
         tick();
         quiet &= !bus.out_valid && !bus.busy;
      end
      chk_eq("rst_ms_quiet", {31'b0, quiet}, 32'd1);
      bus.mode = 32'h0303;
      collect(50, -1);
      chk_eq("restart_nbeats", beats.size(), 32'd3);
      if (beats.size() == 3) chk_eq("restart_b0", beats[0], 32'd10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning): DATA_W, 32, result word width; DEPTH, 64, result buffer words; ADDR_W, 6, buffer address width (log2 DEPTH).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; one clock, reset is asynchronous and active-low.
REQ-004 enable  input  1  global advance qualifier; low freezes all state and outputs.
REQ-005 mode  input  32  command word (same bus as controller); op = mode[3:0], bitser = mode[4], count = mode[15:8].
REQ-006 wr_en  input  1  result buffer write strobe.
REQ-007 wr_addr  input  ADDR_W  result buffer write address.
REQ-008 wr_data  input  DATA_W signed  result word to store.
REQ-009 out_data  output  DATA_W signed  streamed word, or bit in out_data[0] with upper bits zero in bit-serial mode.
REQ-010 out_valid  output  1  out_data holds a valid beat.
REQ-011 out_ready  input  1  sink accepts beat when out_valid && out_ready at clk edge.
REQ-012 busy  output  1  high in LOAD or SEND.
REQ-013 done  output  1  high in DONE state.

Function
REQ-014 Buffer writes SHALL occur on any edge with wr_en high, independent of enable and state.
REQ-015 Buffer reads SHALL be synchronous, 1-cycle latency, read-before-write on address collision (old word returned).
REQ-016 FSM states SHALL be IDLE, LOAD, SEND, DONE; transitions evaluated only when enable=1.
REQ-017 IDLE: op==OP_STREAM with count!=0 -> LOAD, latch count and bitser, read address <= 0; op==OP_STREAM with count==0 -> DONE directly; else stay.
REQ-018 LOAD: one cycle for RAM read; -> SEND with out_valid=1, out_data = word (word mode) or word[0] (bit-serial).
REQ-019 SEND: out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-020 Word mode: each accepted beat advances address; beats = count; next word issued via LOAD (one bubble cycle between beats).
REQ-021 Bit-serial mode: each accepted beat advances bit index 0..DATA_W-1 LSB-first, back-to-back without bubble; after bit DATA_W-1 the address advances via LOAD; beats = count*DATA_W.
REQ-022 Final accepted beat -> DONE, out_valid=0 same edge.
REQ-023 DONE: stay while op==OP_STREAM; op!=OP_STREAM -> IDLE (re-arm requires mode leaving OP_STREAM).
REQ-024 count > DEPTH SHALL be clamped to DEPTH; address SHALL never wrap.
REQ-025 op changing away from OP_STREAM during LOAD/SEND SHALL NOT abort the stream.
REQ-026 enable=0 mid-stream: state, counters, out_data, out_valid frozen; a handshake with enable=0 SHALL NOT count.

Reset
REQ-027 reset low SHALL immediately force IDLE, address/bit/beat counters 0, out_data 0, out_valid 0, busy 0, done 0; buffer contents undefined.
REQ-028 reset low mid-stream SHALL discard the stream; no beat is emitted after reset release until a new OP_STREAM.

Structure
REQ-029 Shared package SHALL hold OP_STREAM (4'h3), the op field positions, the FSM state enum, and DATA_W default.
REQ-030 Buffer SHALL be a sub-module result_ram (1 write port, 1 synchronous read port, parameterised DATA_W/DEPTH).

Verification
REQ-031 Word mode: write 10,-3,7 to addr 0..2; mode=32'h0303, out_ready=1 -> beats 10,-3,7, each followed by a bubble cycle; done after third.
REQ-032 Bit-serial: addr0 = 32'hA5; mode=32'h0113 -> 32 consecutive beats 1,0,1,0,0,1,0,1 then 24 zeros; done.
REQ-033 Backpressure: word mode count=2, out_ready low 5 cycles on first beat -> out_data held at word0, no beat lost or repeated.
REQ-034 Boundaries: count=0 -> DONE next cycle with no out_valid; count=200 -> exactly 64 beats; mode held 0x0303 after DONE -> no restart until mode=0.
REQ-035 Reset mid-stream after 1 of 3 beats -> all outputs 0 asynchronously; new OP_STREAM restarts at addr 0.
REQ-036 enable low 3 cycles mid bit-serial word -> stream resumes at the same bit index, total 32 beats.
